ex_mul_seq: RTL and testbench
=============================

Name: ex_mul_seq

Overview:
- Iterative shift-add multiply sequencer attached to the execute stage.
- Accepts one multiply micro-op from ID/IX (operands already read from the register file), iterates one multiplier bit per cycle, and produces the low WIDTH bits of the product.
- Stalls the pipeline while busy, then presents a single-cycle destination-register write in the same format the IX/MEM writeback path uses.

Parameters:
- WIDTH, 16, operand and result width in bits.
- EARLY_TERM, 1, when 1 the sequence finishes as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (sampled on rising clk edge; 0 = reset).
- start_idix_p3  input  1  multiply request valid; accepted only when ready_ix=1.
- op_a_idix_p3  input  WIDTH  multiplicand (rs value).
- op_b_idix_p3  input  WIDTH  multiplier (rt value).
- dest_reg_idix_p3  input  3  destination register index.
- flush_ix  input  1  abort any in-flight multiply; no writeback.
- ready_ix  output  1  1 in IDLE only.
- stall_ix  output  1  1 in RUN; freezes upstream pipeline stages.
- dest_reg_value_ixmem_p4  output  WIDTH  product, low WIDTH bits.
- dest_reg_index_ixmem_p4  output  3  latched destination index.
- dest_reg_write_valid_ixmem_p4  output  1  single-cycle write strobe.
- iter_cnt_ix  output  $clog2(WIDTH)+1  iterations completed; debug/verification visibility.

Behaviour:
- Reset (rst=0 at a clk edge), regardless of state:
  - state goes to IDLE; ready_ix=1; stall_ix=0.
  - dest_reg_write_valid_ixmem_p4=0.
  - dest_reg_value_ixmem_p4=0, dest_reg_index_ixmem_p4=0, iter_cnt_ix=0.
  - Internal accumulator and operand registers cleared.
  - An in-flight operation is discarded with no writeback.
- States: IDLE, RUN, DONE. Registered, one-hot or binary.
- IDLE:
  - On start_idix_p3=1 and flush_ix=0: latch A=op_a, B=op_b, dest; acc=0; cnt=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN, one iteration per cycle:
  - If B[0], acc <= acc + A, truncated to WIDTH.
  - A <= A<<1, truncated.
  - B <= B>>1, logical.
  - cnt <= cnt+1.
  - Go to DONE when cnt+1 == WIDTH.
  - If EARLY_TERM=1, also go to DONE when (B>>1)==0.
  - At least one RUN cycle always occurs.
- DONE, exactly one cycle:
  - dest_reg_write_valid_ixmem_p4=1.
  - dest_reg_value_ixmem_p4=acc.
  - dest_reg_index_ixmem_p4=latched dest.
  - Next state IDLE. A new start is not accepted in DONE (ready_ix=0).
- Iteration count and latency:
  - n = WIDTH when EARLY_TERM=0.
  - n = max(1, index of highest set bit of op_b + 1) when EARLY_TERM=1.
  - Request accepted at edge T; RUN occupies cycles T+1..T+n; write strobe high in cycle T+n+1.
- Output holding:
  - Outside DONE, dest_reg_write_valid_ixmem_p4=0.
  - Value and index outputs hold their last value.
- Arithmetic:
  - Result = (op_a*op_b) mod 2^WIDTH.
  - Identical for signed two's-complement and unsigned operands; no overflow flag.
- Simultaneous events:
  - start while not ready: ignored; the upstream stage holds it because stall_ix/ready_ix gate issue.
  - flush_ix=1 in any state: next state IDLE, no write strobe. Flush wins over a DONE in the same cycle, so the strobe is suppressed combinationally.
  - flush_ix=1 together with start in IDLE: start is dropped.
- stall_ix is a registered-state decode with no combinational path from start. The cycle the request is accepted therefore does not stall, and upstream must not advance a dependent instruction. The hazard unit treats ready_ix=0 as busy.

Decomposition:
- Shared package (ex_pkg): mul_state_t enum {IDLE, RUN, DONE}, REG_IDX_W=3, DATA_W=16.
- Single module; no sub-module needed.
- The datapath (acc/A/B/cnt registers) and the FSM live in separate always_ff blocks within ex_mul_seq.

Test Plan:
- Early termination: EARLY_TERM=1, op_a=3, op_b=5, dest=2 → n=3; strobe 4 cycles after accept; value 0x000F, index 2; ready_ix back to 1 the next cycle.
- Full length with wrap: op_a=0xFFFF, op_b=0xFFFF → n=16; strobe at accept+17; value 0x0001. Repeat with EARLY_TERM=0 and op_b=5: still 16 RUN cycles, value 0x000F.
- Zero multiplier: op_b=0, op_a=0x1234 → exactly 1 RUN cycle; strobe at accept+2; value 0x0000.
- Flush mid-run: op_a=7, op_b=0x8000; assert flush_ix for 1 cycle at accept+5 → no strobe ever; IDLE the next cycle. A following 2*3 request yields 0x0006.
- Busy and reset: a second start asserted during RUN and DONE is ignored (only one strobe). Then rst=0 for one cycle mid-RUN → all outputs 0, ready_ix=1, no strobe afterward.
- Back-to-back: start again in the first IDLE cycle after DONE (0x0010*0x0010 → 0x0100); both strobes appear, separated by at least n+2 cycles, with correct indices.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: datapath widths and the multiply sequencer state type.
package ex_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier for the execute stage: one multiplier bit per cycle,
// stalls upstream while running and emits a one-cycle writeback of the low product bits.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_idix_p3,
    input  logic [WIDTH-1:0]       op_a_idix_p3,
    input  logic [WIDTH-1:0]       op_b_idix_p3,
    input  logic [REG_IDX_W-1:0]   dest_reg_idix_p3,
    input  logic                   flush_ix,
    output logic                   ready_ix,
    output logic                   stall_ix,
    output logic [WIDTH-1:0]       dest_reg_value_ixmem_p4,
    output logic [REG_IDX_W-1:0]   dest_reg_index_ixmem_p4,
    output logic                   dest_reg_write_valid_ixmem_p4,
    output logic [$clog2(WIDTH):0] iter_cnt_ix
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_t           state, state_next;
    logic [WIDTH-1:0]     a_q, b_q, acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [WIDTH-1:0]     value_q;
    logic [REG_IDX_W-1:0] index_q;

    logic [WIDTH-1:0]     acc_step;
    logic [WIDTH-1:0]     b_shift;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 last_iter;

    assign acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
    assign b_shift   = b_q >> 1;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_iter = (cnt_inc == CNT_W'(WIDTH)) || (EARLY_TERM && (b_shift == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every other transition, including a pending start.
    always_comb begin
        state_next = state;
        if (flush_ix) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_idix_p3) state_next = RUN;
                RUN:     if (last_iter) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The write stage is gated combinationally by flush so a late abort still kills the strobe.
    always_comb begin
        ready_ix                      = 1'b0;
        stall_ix                      = 1'b0;
        dest_reg_write_valid_ixmem_p4 = 1'b0;
        case (state)
            IDLE:    ready_ix = 1'b1;
            RUN:     stall_ix = 1'b1;
            DONE:    dest_reg_write_valid_ixmem_p4 = !flush_ix;
            default: ;
        endcase
    end

    // The result registers load on the RUN->DONE edge so they already hold the product during DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dest_q  <= '0;
            value_q <= '0;
            index_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_idix_p3 && !flush_ix) begin
                        a_q    <= op_a_idix_p3;
                        b_q    <= op_b_idix_p3;
                        dest_q <= dest_reg_idix_p3;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    a_q   <= a_q << 1;
                    b_q   <= b_shift;
                    cnt_q <= cnt_inc;
                    if (state_next == DONE) begin
                        value_q <= acc_step;
                        index_q <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dest_reg_value_ixmem_p4 = value_q;
    assign dest_reg_index_ixmem_p4 = index_q;
    assign iter_cnt_ix             = cnt_q;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Bench for ex_mul_seq: one early-terminating and one full-length instance share stimulus
// and are checked against an arithmetic reference model.
module tb_ex_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [2:0]  dest = '0;
    logic        flush = 1'b0;

    logic        rdy  [2];
    logic        stl  [2];
    logic [15:0] val  [2];
    logic [2:0]  idx  [2];
    logic        wv   [2];
    logic [4:0]  iter [2];

    int n_checks = 0;
    int n_fail   = 0;

    int          lat     [2];
    int          n_strobe[2];
    logic [15:0] got_val [2];
    logic [2:0]  got_idx [2];
    logic [4:0]  got_iter[2];

    always #5 clk = ~clk;

    ex_mul_seq #(.WIDTH(16), .EARLY_TERM(1'b1)) dut_et (
        .clk(clk), .rst(rst), .start_idix_p3(start), .op_a_idix_p3(op_a),
        .op_b_idix_p3(op_b), .dest_reg_idix_p3(dest), .flush_ix(flush),
        .ready_ix(rdy[0]), .stall_ix(stl[0]), .dest_reg_value_ixmem_p4(val[0]),
        .dest_reg_index_ixmem_p4(idx[0]), .dest_reg_write_valid_ixmem_p4(wv[0]),
        .iter_cnt_ix(iter[0])
    );

    ex_mul_seq #(.WIDTH(16), .EARLY_TERM(1'b0)) dut_full (
        .clk(clk), .rst(rst), .start_idix_p3(start), .op_a_idix_p3(op_a),
        .op_b_idix_p3(op_b), .dest_reg_idix_p3(dest), .flush_ix(flush),
        .ready_ix(rdy[1]), .stall_ix(stl[1]), .dest_reg_value_ixmem_p4(val[1]),
        .dest_reg_index_ixmem_p4(idx[1]), .dest_reg_write_valid_ixmem_p4(wv[1]),
        .iter_cnt_ix(iter[1])
    );

    // Reference: iterations needed, from the position of the highest set multiplier bit.
    function automatic int model_n(input bit early, input logic [15:0] b);
        int hi;
        if (!early) return 16;
        hi = 0;
        for (int k = 0; k < 16; k++) if (b[k]) hi = k + 1;
        return (hi < 1) ? 1 : hi;
    endfunction

    function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        dest  = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Watches both instances for a bounded window after an accept edge; cycle 1 is the first after it.
    task automatic wait_strobe(input int cycles);
        for (int u = 0; u < 2; u++) begin
            lat[u] = -1; n_strobe[u] = 0; got_val[u] = 'x; got_idx[u] = 'x; got_iter[u] = 'x;
        end
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (wv[u] === 1'b1) begin
                    if (n_strobe[u] == 0) begin
                        lat[u] = c; got_val[u] = val[u]; got_idx[u] = idx[u]; got_iter[u] = iter[u];
                    end
                    n_strobe[u]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({rdy[u], stl[u], wv[u]} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL reset_ctrl u%0d: got rdy/stl/wv=%b%b%b want 100", u, rdy[u], stl[u], wv[u]);
            end
            n_checks++;
            if ({val[u], idx[u], iter[u]} !== 24'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_data u%0d: got val=%h idx=%0d iter=%0d want 0", u, val[u], idx[u], iter[u]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        for (int u = 0; u < 2; u++) begin
            int n;
            n = model_n(u == 0, b);
            n_checks++;
            if (lat[u] !== n + 1 || n_strobe[u] !== 1) begin
                n_fail++;
                $display("[TB] FAIL %s_lat u%0d: got lat=%0d strobes=%0d want lat=%0d strobes=1", tag, u, lat[u], n_strobe[u], n + 1);
            end
            n_checks++;
            if (got_val[u] !== model_prod(a, b) || got_idx[u] !== d) begin
                n_fail++;
                $display("[TB] FAIL %s_val u%0d: got %h/%0d want %h/%0d (a=%h b=%h)", tag, u, got_val[u], got_idx[u], model_prod(a, b), d, a, b);
            end
            n_checks++;
            if (got_iter[u] !== 5'(n)) begin
                n_fail++;
                $display("[TB] FAIL %s_iter u%0d: got %0d want %0d", tag, u, got_iter[u], n);
            end
        end
    endtask

    task automatic test_early_term();
        issue(16'd3, 16'd5, 3'd2);
        wait_strobe(4);
        @(negedge clk);
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL early_ready: got %b want 1", rdy[0]);
        end
        wait_strobe_rest();
    endtask

    // Finishes the window for the slow instance after the early one has been examined.
    task automatic wait_strobe_rest();
        for (int c = 6; c <= 20; c++) begin
            @(negedge clk);
            if (wv[1] === 1'b1) begin
                if (n_strobe[1] == 0) begin
                    lat[1] = c; got_val[1] = val[1]; got_idx[1] = idx[1]; got_iter[1] = iter[1];
                end
                n_strobe[1]++;
            end
            if (wv[0] === 1'b1) n_strobe[0]++;
        end
        check_op("early", 16'd3, 16'd5, 3'd2);
    endtask

    task automatic test_full_wrap();
        issue(16'hFFFF, 16'hFFFF, 3'd7);
        wait_strobe(22);
        check_op("wrap", 16'hFFFF, 16'hFFFF, 3'd7);
    endtask

    task automatic test_zero_mult();
        issue(16'h1234, 16'h0000, 3'd1);
        wait_strobe(22);
        check_op("zero", 16'h1234, 16'h0000, 3'd1);
    endtask

    task automatic test_flush();
        issue(16'd7, 16'h8000, 3'd3);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (rdy[u] !== 1'b1 || stl[u] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL flush_idle u%0d: got rdy=%b stl=%b want 1/0", u, rdy[u], stl[u]);
            end
        end
        wait_strobe(25);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_strobe[u] !== 0) begin
                n_fail++;
                $display("[TB] FAIL flush_nostrobe u%0d: got %0d strobes want 0", u, n_strobe[u]);
            end
        end
        issue(16'd2, 16'd3, 3'd4);
        wait_strobe(22);
        check_op("post_flush", 16'd2, 16'd3, 3'd4);
    endtask

    task automatic test_busy_reset();
        issue(16'h00AB, 16'h00FF, 3'd5);
        start = 1'b1;
        for (int u = 0; u < 2; u++) begin
            lat[u] = -1; n_strobe[u] = 0; got_val[u] = 'x; got_idx[u] = 'x; got_iter[u] = 'x;
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (start && rdy[0] === 1'b1) start = 1'b0;
            else if (start) begin op_a = 16'($urandom); op_b = 16'($urandom); dest = 3'($urandom); end
            for (int u = 0; u < 2; u++) begin
                if (wv[u] === 1'b1) begin
                    if (n_strobe[u] == 0) begin
                        lat[u] = c; got_val[u] = val[u]; got_idx[u] = idx[u]; got_iter[u] = iter[u];
                    end
                    n_strobe[u]++;
                end
            end
        end
        start = 1'b0;
        check_op("busy", 16'h00AB, 16'h00FF, 3'd5);

        issue(16'h1111, 16'hFFFF, 3'd6);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({rdy[u], stl[u], wv[u], val[u], idx[u], iter[u]} !== {3'b100, 24'h0}) begin
                n_fail++;
                $display("[TB] FAIL midrun_reset u%0d: got rdy=%b stl=%b wv=%b val=%h idx=%0d iter=%0d want 1 0 0 0 0 0",
                         u, rdy[u], stl[u], wv[u], val[u], idx[u], iter[u]);
            end
        end
        rst = 1'b1;
        wait_strobe(25);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (n_strobe[u] !== 0) begin
                n_fail++;
                $display("[TB] FAIL reset_nostrobe u%0d: got %0d strobes want 0", u, n_strobe[u]);
            end
        end
    endtask

    // Second request goes in during the early instance's first IDLE cycle after its DONE.
    task automatic test_back_to_back();
        int s1, s2, seen;
        logic [15:0] v1, v2;
        logic [2:0]  i1, i2;
        bit issued;
        s1 = -1; s2 = -1; seen = 0; issued = 0; v1 = 'x; v2 = 'x; i1 = 'x; i2 = 'x;
        issue(16'h0010, 16'h0010, 3'd5);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (wv[0] === 1'b1) begin
                if (seen == 0) begin s1 = c; v1 = val[0]; i1 = idx[0]; end
                else if (seen == 1) begin s2 = c; v2 = val[0]; i2 = idx[0]; end
                seen++;
            end else if (seen == 1 && !issued && rdy[0] === 1'b1) begin
                op_a = 16'h0003; op_b = 16'h0007; dest = 3'd6; start = 1'b1; issued = 1;
            end
        end
        start = 1'b0;
        n_checks++;
        if (seen !== 2 || s1 !== model_n(1, 16'h0010) + 1 || s2 - s1 !== model_n(1, 16'h0007) + 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_timing: got strobes=%0d s1=%0d s2=%0d want 2 %0d %0d",
                     seen, s1, s2, model_n(1, 16'h0010) + 1, model_n(1, 16'h0010) + model_n(1, 16'h0007) + 3);
        end
        n_checks++;
        if (v1 !== model_prod(16'h0010, 16'h0010) || i1 !== 3'd5 || v2 !== model_prod(16'h0003, 16'h0007) || i2 !== 3'd6) begin
            n_fail++;
            $display("[TB] FAIL b2b_data: got %h/%0d %h/%0d want 0100/5 0015/6", v1, i1, v2, i2);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [15:0] a, b, mask;
            logic [2:0]  d;
            int          k;
            k    = $urandom_range(0, 16);
            mask = (k == 16) ? 16'hFFFF : 16'((32'h1 << k) - 1);
            a    = 16'($urandom);
            b    = 16'($urandom) & mask;
            d    = 3'($urandom);
            issue(a, b, d);
            wait_strobe(20);
            check_op("rand", a, b, d);
        end
    endtask

    initial begin
        test_reset();
        test_early_term();
        test_full_wrap();
        test_zero_mult();
        test_flush();
        test_busy_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
